// File: rtl/xcom_pkg.sv
// Shared types for the XCOM net-command queue: command record, FSM state encoding and field widths.
package xcom_pkg;

  localparam int XCOM_OP_W  = 8;
  localparam int XCOM_DT_W  = 32;
  localparam int XCOM_CMD_W = XCOM_OP_W + XCOM_DT_W;

  typedef struct packed {
    logic [XCOM_OP_W-1:0] op;
    logic [XCOM_DT_W-1:0] dt;
  } xcom_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } xcom_cmdq_st_t;

endpackage

// File: rtl/xcom_cmdq_fifo.sv
// Single-clock FIFO of packed xcom_cmd_t words with push/pop/flush and registered occupancy.
// Flush wins over push and pop in the same cycle; pushes while full and pops while empty are ignored.
module xcom_cmdq_fifo
  import xcom_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  x_clk_i,
  input  logic                  c_rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic [XCOM_CMD_W-1:0] wdata_i,
  output logic [XCOM_CMD_W-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [AW:0]           cnt_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [XCOM_CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (cnt == FULL_CNT);
  assign empty_o = (cnt == '0);
  assign cnt_o   = cnt;
  assign rdata_o = mem[rd_ptr];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge x_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge x_clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/xcom_net_cmd_queue.sv
// Net-command queue feeding the XCOM four-phase req/ack port from a valid/ready push interface.
// Optional statistics (sent count, occupancy watermark) are built when XCOM_CMDQ_STATS_EN is defined.
module xcom_net_cmd_queue
  import xcom_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        x_clk_i,
  input  logic        c_rst_ni,
  input  logic        in_vld_i,
  output logic        in_rdy_o,
  input  logic [7:0]  in_op_i,
  input  logic [31:0] in_dt_i,
  input  logic        flush_i,
  output logic        cmd_net_req_o,
  input  logic        cmd_net_ack_i,
  output logic [7:0]  cmd_op_o,
  output logic [31:0] cmd_dt_o,
  output logic [AW:0] q_cnt_o,
  output logic        q_empty_o,
  output logic        busy_o,
  output logic        err_ovf_o,
  output logic [15:0] sent_cnt_o,
  output logic [AW:0] q_max_o
);

  // Handshake: a push transfers when in_vld_i & in_rdy_o at a rising edge; in_rdy_o depends only
  // on registered occupancy. Toward XCOM, req rises with op/dt stable, stays until ack=1, then
  // the queue waits for ack=0 before it may raise req again.

  xcom_cmdq_st_t         state_q;
  xcom_cmdq_st_t         state_d;
  logic                  full;
  logic                  empty;
  logic [AW:0]           cnt;
  logic [XCOM_CMD_W-1:0] head_w;
  xcom_cmd_t             head;
  logic                  launch;
  logic                  ovf_q;
  logic [7:0]            op_q;
  logic [31:0]           dt_q;

  assign head = xcom_cmd_t'(head_w);

  xcom_cmdq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .x_clk_i (x_clk_i),
    .c_rst_ni(c_rst_ni),
    .push_i  (in_vld_i),
    .pop_i   (launch),
    .flush_i (flush_i),
    .wdata_i ({in_op_i, in_dt_i}),
    .rdata_o (head_w),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );

  always_ff @(posedge x_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // A flush in the same cycle blocks the launch so flushed entries never reach XCOM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty && !cmd_net_ack_i && !flush_i) state_d = REQ;
      REQ:     if (cmd_net_ack_i) state_d = DROP;
      DROP:    if (!cmd_net_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch        = (state_q == IDLE) && (state_d == REQ);
    cmd_net_req_o = (state_q == REQ);
    busy_o        = (state_q != IDLE) || !empty;
  end

  always_ff @(posedge x_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      op_q  <= '0;
      dt_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (launch) begin
        op_q <= head.op;
        dt_q <= head.dt;
      end
      if (in_vld_i && full) ovf_q <= 1'b1;
    end
  end

  assign in_rdy_o  = ~full;
  assign q_cnt_o   = cnt;
  assign q_empty_o = empty;
  assign err_ovf_o = ovf_q;
  assign cmd_op_o  = op_q;
  assign cmd_dt_o  = dt_q;

`ifdef XCOM_CMDQ_STATS_EN
  logic [15:0] sent_q;
  logic [AW:0] max_q;

  always_ff @(posedge x_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      sent_q <= '0;
      max_q  <= '0;
    end else begin
      if (state_q == REQ && cmd_net_ack_i) sent_q <= sent_q + 16'd1;
      if (cnt > max_q) max_q <= cnt;
    end
  end

  assign sent_cnt_o = sent_q;
  assign q_max_o    = max_q;
`else
  assign sent_cnt_o = '0;
  assign q_max_o    = '0;
`endif

endmodule

// File: tb/tb_xcom_net_cmd_queue.sv
// Self-checking bench for xcom_net_cmd_queue (DEPTH=8); stats checks follow XCOM_CMDQ_STATS_EN.
module tb_xcom_net_cmd_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic [7:0]  in_op = '0;
  logic [31:0] in_dt = '0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic        in_rdy;
  logic        req;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_dt;
  logic [AW:0] q_cnt;
  logic        q_empty;
  logic        busy;
  logic        err_ovf;
  logic [15:0] sent_cnt;
  logic [AW:0] q_max;

  logic [39:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_rise = 0;
  logic        req_prev = 1'b0;

  typedef struct {
    logic        vld;
    logic        ack;
    logic [7:0]  op;
    logic [31:0] dt;
    logic        acc;
    logic [AW:0] e_cnt;
    logic        e_rdy;
    logic        e_ovf;
    logic        e_req;
  } vec_t;

  vec_t tbl[11];

  xcom_net_cmd_queue #(.DEPTH(DEPTH)) dut (
    .x_clk_i      (clk),
    .c_rst_ni     (rst_n),
    .in_vld_i     (in_vld),
    .in_rdy_o     (in_rdy),
    .in_op_i      (in_op),
    .in_dt_i      (in_dt),
    .flush_i      (flush),
    .cmd_net_req_o(req),
    .cmd_net_ack_i(ack),
    .cmd_op_o     (cmd_op),
    .cmd_dt_o     (cmd_dt),
    .q_cnt_o      (q_cnt),
    .q_empty_o    (q_empty),
    .busy_o       (busy),
    .err_ovf_o    (err_ovf),
    .sent_cnt_o   (sent_cnt),
    .q_max_o      (q_max)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting on DUT", name);
  endtask

  // scoreboard: every rising req must present the oldest expected command
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
    end else begin
      if (req && !req_prev) begin
        n_rise++;
        if (exp_q.size() == 0) timeout("unexpected_req");
        else chk("req_order", {cmd_op, cmd_dt}, exp_q.pop_front());
      end
      req_prev = req;
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic push_word(input logic [7:0] op, input logic [31:0] dt);
    in_vld = 1'b1;
    in_op  = op;
    in_dt  = dt;
    exp_q.push_back({op, dt});
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic serve_one(input int dly);
    int t;
    t = 0;
    while (!req && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req) begin
      timeout("serve_req_rise");
    end else begin
      repeat (dly) @(negedge clk);
      ack = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (req && t < 50);
      if (req) timeout("serve_req_fall");
      ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int rise0;

    // stimulus table: fill to overflow with ack held high, then drop ack with a concurrent push
    for (int i = 0; i < 9; i++) begin
      tbl[i].vld   = 1'b1;
      tbl[i].ack   = 1'b1;
      tbl[i].op    = 8'h10 + 8'(i);
      tbl[i].dt    = 32'(i);
      tbl[i].acc   = (i < 8);
      tbl[i].e_cnt = (i < 8) ? 4'(i + 1) : 4'd8;
      tbl[i].e_rdy = (i < 7);
      tbl[i].e_ovf = (i == 8);
      tbl[i].e_req = 1'b0;
    end
    tbl[9]  = '{vld: 1'b0, ack: 1'b1, op: 8'h00, dt: 32'h0, acc: 1'b0,
                e_cnt: 4'd8, e_rdy: 1'b0, e_ovf: 1'b1, e_req: 1'b0};
    tbl[10] = '{vld: 1'b1, ack: 1'b0, op: 8'hEE, dt: 32'h0000_0BAD, acc: 1'b0,
                e_cnt: 4'd7, e_rdy: 1'b1, e_ovf: 1'b1, e_req: 1'b1};

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_rdy", in_rdy, 1);
    chk("rst_empty", q_empty, 1);
    chk("rst_cnt", q_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_opdt", {cmd_op, cmd_dt}, 0);
    chk("rst_sent", sent_cnt, 0);
    chk("rst_qmax", q_max, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single command: latency, hold while ack low, drop, return to idle
    push_word(8'h9A, 32'h1234_5678);
    chk("single_req_n", req, 0);
    chk("single_cnt_n", q_cnt, 1);
    @(negedge clk);
    chk("single_req_n1", req, 1);
    chk("single_op", cmd_op, 8'h9A);
    chk("single_dt", cmd_dt, 32'h1234_5678);
    chk("single_cnt_n1", q_cnt, 0);
    chk("single_busy", busy, 1);
    repeat (5) @(negedge clk);
    chk("single_req_hold", req, 1);
    ack = 1'b1;
    @(negedge clk);
    chk("single_req_fall", req, 0);
    chk("single_busy_drop", busy, 1);
    chk("single_op_hold", cmd_op, 8'h9A);
    ack = 1'b0;
    @(negedge clk);
    chk("single_busy_idle", busy, 0);
    chk("single_empty", q_empty, 1);
    repeat (2) @(negedge clk);
    chk("idle_empty_req", req, 0);
    chk("idle_empty_dt", cmd_dt, 32'h1234_5678);

    // simultaneous push and pop at count 3
    ack = 1'b1;
    for (int i = 0; i < 3; i++) push_word(8'h30 + 8'(i), 32'hA000_0000 + 32'(i));
    chk("pp_cnt3", q_cnt, 3);
    ack = 1'b0;
    push_word(8'h33, 32'hA000_0003);
    chk("pp_cnt_same", q_cnt, 3);
    chk("pp_req", req, 1);
    for (int i = 0; i < 4; i++) serve_one($urandom_range(0, 3));
    chk("pp_drain", q_cnt, 0);

    // table-driven burst fill, overflow, refused push during concurrent pop
    for (int i = 0; i < 11; i++) begin
      in_vld = tbl[i].vld;
      ack    = tbl[i].ack;
      in_op  = tbl[i].op;
      in_dt  = tbl[i].dt;
      if (tbl[i].acc) exp_q.push_back({tbl[i].op, tbl[i].dt});
      @(negedge clk);
      in_vld = 1'b0;
      chk($sformatf("tbl%0d_cnt", i), q_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_rdy", i), in_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_ovf", i), err_ovf, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_req", i), req, tbl[i].e_req);
    end
    ack = 1'b0;
    for (int i = 0; i < 8; i++) serve_one($urandom_range(0, 3));
    chk("burst_sb_empty", exp_q.size(), 0);
    chk("burst_q_empty", q_empty, 1);

    // flush during REQ with 4 queued
    ack = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'h50 + 8'(i), 32'hF000_0000 + 32'(i));
    chk("fl_cnt5", q_cnt, 5);
    ack = 1'b0;
    @(negedge clk);
    chk("fl_req", req, 1);
    chk("fl_cnt4", q_cnt, 4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    chk("fl_cnt0", q_cnt, 0);
    chk("fl_req_kept", req, 1);
    chk("fl_op_kept", {cmd_op, cmd_dt}, {8'h50, 32'hF000_0000});
    rise0 = n_rise;
    serve_one(2);
    repeat (10) @(negedge clk);
    chk("fl_no_more_req", n_rise, rise0);
    in_vld = 1'b1;
    in_op  = 8'h77;
    in_dt  = 32'h7777_7777;
    flush  = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    flush  = 1'b0;
    chk("fl_push_cnt", q_cnt, 0);
    repeat (3) @(negedge clk);
    chk("fl_push_noreq", req, 0);

    // reset mid-handshake, then ack held high after reset
    push_word(8'hC1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rm_req", req, 1);
    ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_req0", req, 0);
    chk("rm_opdt0", {cmd_op, cmd_dt}, 0);
    chk("rm_ovf0", err_ovf, 0);
    chk("rm_rdy1", in_rdy, 1);
    chk("rm_empty1", q_empty, 1);
    chk("rm_busy0", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_word(8'hC2, 32'h0BAD_F00D);
    repeat (4) @(negedge clk);
    chk("rm_ack_block", req, 0);
    chk("rm_ack_cnt", q_cnt, 1);
    ack = 1'b0;
    serve_one(1);
    chk("rm_sb_empty", exp_q.size(), 0);

    // statistics: 20 commands with peak occupancy 5
    do_reset();
    ack = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'h60 + 8'(i), 32'(100 + i));
    ack = 1'b0;
    for (int i = 0; i < 5; i++) serve_one($urandom_range(0, 2));
    for (int i = 0; i < 15; i++) begin
      push_word(8'h70 + 8'(i), 32'(200 + i));
      serve_one($urandom_range(0, 2));
    end
    chk("st_sb_empty", exp_q.size(), 0);
`ifdef XCOM_CMDQ_STATS_EN
    chk("st_sent", sent_cnt, 16'd20);
    chk("st_qmax", q_max, 4'd5);
`else
    chk("st_sent_off", sent_cnt, 0);
    chk("st_qmax_off", q_max, 0);
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
